jt7759_rom_arb: RTL and testbench
=================================

JT7759_ROM_ARB -- requirements
Module: jt7759_rom_arb

Interface
REQ-001 SHALL have parameter AW, default 17, ROM address width (128 kB sample ROM).
REQ-002 SHALL have parameter TOUT, default 8'd255, ROM wait timeout in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports ctl_cs  input  1 and ctl_addr  input  AW: control-FSM read request and byte address.
REQ-006 SHALL have ports ctl_data  output  8 and ctl_ok  output  1: control read data and one-cycle done pulse.
REQ-007 SHALL have ports dec_cs  input  1 and dec_addr  input  AW: ADPCM decoder read request and address.
REQ-008 SHALL have ports dec_data  output  8 and dec_ok  output  1: decoder read data and done pulse.
REQ-009 SHALL have ports rom_cs  output  1 and rom_addr  output  AW: shared ROM request and address.
REQ-010 SHALL have ports rom_data  input  8 and rom_ok  input  1: ROM data and data-valid.
REQ-011 SHALL have port tout_err  output  1: one-cycle pulse on ROM timeout.

Function
REQ-012 SHALL implement FSM states IDLE, HIT, BUSY, DONE.
REQ-013 Requester handshake SHALL be: cs held high with stable addr until its ok pulse; ok SHALL be exactly one cycle; data SHALL hold until that requester's next ok.
REQ-014 SHALL keep per requester a one-entry cache (last addr, data, valid bit); valid SHALL clear on reset.
REQ-015 In IDLE, a requester whose cs is high, valid set and addr equal to cached addr SHALL take HIT: ok at the next cycle, no rom_cs.
REQ-016 Otherwise in IDLE, a requesting side SHALL be granted: rom_cs high and rom_addr = its addr from the next cycle; state BUSY.
REQ-017 When both sides request misses in the same cycle, grant SHALL be round-robin: the side not granted last wins; the last-grant flag resets to ctl, so the first tie goes to dec.
REQ-018 Hits SHALL take precedence over misses in the same cycle; a dec hit beats a ctl hit; hits do not change the round-robin flag.
REQ-019 In BUSY, rom_ok SHALL be ignored in the first BUSY cycle (stale-ok guard) and accepted from the second onward.
REQ-020 On accepted rom_ok: rom_data SHALL be latched into the granted side's data and cache; valid set; rom_cs low next cycle; ok pulsed next cycle (DONE); then IDLE.
REQ-021 Miss latency SHALL be: cs sampled at n, rom_cs at n+1, earliest accepted rom_ok at n+2, ok at n+3.
REQ-022 DONE SHALL last one cycle; a new grant SHALL NOT issue in DONE, so rom_cs is low for at least one cycle between transactions.
REQ-023 If the granted side drops cs during BUSY, the arbiter SHALL drop rom_cs next cycle, return to IDLE, give no ok, and leave the cache unchanged.
REQ-024 A granted side's addr change while cs stays high SHALL be ignored; the latched rom_addr holds.
REQ-025 An 8-bit wait counter SHALL clear on grant and increment each BUSY cycle; at TOUT without accepted rom_ok the arbiter SHALL:
- pulse tout_err and ok together;
- return data 8'h00;
- leave the cache valid bit clear;
- go to IDLE.
REQ-026 rom_ok outside BUSY SHALL be ignored.

Reset
REQ-027 While rst_n is low, all of the following SHALL hold: state IDLE; rom_cs, ctl_ok, dec_ok, tout_err at 0; rom_addr, ctl_data, dec_data at 0; both caches invalid; round-robin flag at ctl; wait counter at 0.
REQ-028 Reset mid-BUSY SHALL abort immediately: rom_cs low asynchronously, no ok after release.
REQ-029 The first request after rst_n release SHALL be a miss.

Verification
REQ-030 Bench SHALL cover a single miss: dec_cs=1, dec_addr=17'h00100, rom_ok returned 3 cycles after rom_cs with rom_data=8'hA5 -> dec_ok one pulse, dec_data=8'hA5, rom_addr=17'h00100.
REQ-031 Bench SHALL cover a hit: repeat dec_addr=17'h00100 after REQ-030 -> dec_ok at the next cycle, rom_cs stays 0.
REQ-032 Bench SHALL cover a tie: ctl_addr=17'h00010 and dec_addr=17'h00200 asserted together after reset -> dec served first, then ctl; rom_cs has a low gap of at least 1 cycle between them.
REQ-033 Bench SHALL cover timeout: ctl_cs=1 with rom_ok held 0 -> after 255 BUSY cycles ctl_ok=1, tout_err=1, ctl_data=8'h00; the next same-address request misses.
REQ-034 Bench SHALL cover an early and a stray ok: rom_ok=1 in the first BUSY cycle is ignored; rom_ok in IDLE is ignored; the transaction completes on the later rom_ok.
REQ-035 Bench SHALL cover abort and reset: dec_cs dropped in BUSY -> no dec_ok, rom_cs low next cycle; rst_n low in BUSY -> rom_cs=0 at once and cache misses afterwards.

Source files
------------

// File: rtl/jt7759_rom_arb.sv
`timescale 1ns/1ps
`default_nettype none
// jt7759_rom_arb - shares the sample-ROM port between the control FSM and the
// ADPCM decoder, with a one-entry read cache per side and a wait timeout. rev 1.0
module jt7759_rom_arb #(
    parameter int         AW   = 17,
    parameter logic [7:0] TOUT = 8'd255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ctl_cs,
    input  logic [AW-1:0] ctl_addr,
    output logic [7:0]    ctl_data,
    output logic          ctl_ok,
    input  logic          dec_cs,
    input  logic [AW-1:0] dec_addr,
    output logic [7:0]    dec_data,
    output logic          dec_ok,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic          tout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIT  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_sel_dec;
    logic          r_last_dec;
    logic [7:0]    r_cnt;
    logic          r_ctl_vld;
    logic          r_dec_vld;
    logic [AW-1:0] r_ctl_caddr;
    logic [AW-1:0] r_dec_caddr;
    logic [7:0]    r_ctl_cdata;
    logic [7:0]    r_dec_cdata;
    logic          r_ctl_ok;
    logic          r_dec_ok;
    logic          r_tout;
    logic [7:0]    r_ctl_data;
    logic [7:0]    r_dec_data;
    logic          r_rom_cs;
    logic [AW-1:0] r_rom_addr;

    logic          w_ctl_hit;
    logic          w_dec_hit;
    logic          w_ctl_miss;
    logic          w_dec_miss;
    logic          w_gnt_dec;
    logic          w_gnt_cs;
    logic [7:0]    w_cnt_nxt;
    logic          w_rom_acc;
    logic          w_tout;

    assign w_ctl_hit  = ctl_cs & r_ctl_vld & (ctl_addr == r_ctl_caddr);
    assign w_dec_hit  = dec_cs & r_dec_vld & (dec_addr == r_dec_caddr);
    assign w_ctl_miss = ctl_cs & ~w_ctl_hit;
    assign w_dec_miss = dec_cs & ~w_dec_hit;
    // On a tie the side that did not win the previous grant goes first.
    assign w_gnt_dec  = w_dec_miss & (~w_ctl_miss | ~r_last_dec);
    assign w_gnt_cs   = r_sel_dec ? dec_cs : ctl_cs;
    assign w_cnt_nxt  = r_cnt + 8'd1;
    // r_cnt is still zero in the first BUSY cycle, where an ok may be stale.
    assign w_rom_acc  = rom_ok & (r_cnt != 8'd0);
    assign w_tout     = (w_cnt_nxt == TOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel_dec   <= 1'b0;
            r_last_dec  <= 1'b0;
            r_cnt       <= 8'd0;
            r_ctl_vld   <= 1'b0;
            r_dec_vld   <= 1'b0;
            r_ctl_caddr <= '0;
            r_dec_caddr <= '0;
            r_ctl_cdata <= 8'd0;
            r_dec_cdata <= 8'd0;
            r_ctl_ok    <= 1'b0;
            r_dec_ok    <= 1'b0;
            r_tout      <= 1'b0;
            r_ctl_data  <= 8'd0;
            r_dec_data  <= 8'd0;
            r_rom_cs    <= 1'b0;
            r_rom_addr  <= '0;
        end else begin
            r_ctl_ok <= 1'b0;
            r_dec_ok <= 1'b0;
            r_tout   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_dec_hit) begin
                        r_dec_ok   <= 1'b1;
                        r_dec_data <= r_dec_cdata;
                        r_state    <= HIT;
                    end else if (w_ctl_hit) begin
                        r_ctl_ok   <= 1'b1;
                        r_ctl_data <= r_ctl_cdata;
                        r_state    <= HIT;
                    end else if (w_ctl_miss | w_dec_miss) begin
                        r_sel_dec  <= w_gnt_dec;
                        r_last_dec <= w_gnt_dec;
                        r_rom_cs   <= 1'b1;
                        r_rom_addr <= w_gnt_dec ? dec_addr : ctl_addr;
                        r_cnt      <= 8'd0;
                        r_state    <= BUSY;
                    end
                end
                HIT: begin
                    r_state <= IDLE;
                end
                BUSY: begin
                    r_cnt <= w_cnt_nxt;
                    if (!w_gnt_cs) begin
                        r_rom_cs <= 1'b0;
                        r_state  <= IDLE;
                    end else if (w_rom_acc || w_tout) begin
                        r_rom_cs <= 1'b0;
                        r_state  <= DONE;
                        r_tout   <= ~w_rom_acc;
                        if (r_sel_dec) begin
                            r_dec_ok    <= 1'b1;
                            r_dec_data  <= w_rom_acc ? rom_data : 8'h00;
                            r_dec_vld   <= w_rom_acc;
                            r_dec_caddr <= r_rom_addr;
                            r_dec_cdata <= rom_data;
                        end else begin
                            r_ctl_ok    <= 1'b1;
                            r_ctl_data  <= w_rom_acc ? rom_data : 8'h00;
                            r_ctl_vld   <= w_rom_acc;
                            r_ctl_caddr <= r_rom_addr;
                            r_ctl_cdata <= rom_data;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ctl_data = r_ctl_data;
    assign ctl_ok   = r_ctl_ok;
    assign dec_data = r_dec_data;
    assign dec_ok   = r_dec_ok;
    assign rom_cs   = r_rom_cs;
    assign rom_addr = r_rom_addr;
    assign tout_err = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_jt7759_rom_arb.sv
`timescale 1ns/1ps
`default_nettype none
// tb_jt7759_rom_arb - vector table, hand sequences and randomized requests
// against a transaction-level model of the two-port cached ROM arbiter.
module tb_jt7759_rom_arb;
    localparam int AW     = 17;
    localparam int TO_LAT = 1000;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          ctl_cs   = 1'b0;
    logic [AW-1:0] ctl_addr = '0;
    logic [7:0]    ctl_data;
    logic          ctl_ok;
    logic          dec_cs   = 1'b0;
    logic [AW-1:0] dec_addr = '0;
    logic [7:0]    dec_data;
    logic          dec_ok;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'd0;
    logic          rom_ok   = 1'b0;
    logic          tout_err;

    always #5 clk = ~clk;

    jt7759_rom_arb #(.AW(AW), .TOUT(8'd255)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctl_cs(ctl_cs), .ctl_addr(ctl_addr), .ctl_data(ctl_data), .ctl_ok(ctl_ok),
        .dec_cs(dec_cs), .dec_addr(dec_addr), .dec_data(dec_data), .dec_ok(dec_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .tout_err(tout_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: per-side cache entry and who won the last grant (1 = dec).
    bit            m_vld[2];
    logic [AW-1:0] m_addr[2];
    logic [7:0]    m_dat[2];
    bit            m_last;

    typedef struct {
        bit            ce;
        logic [AW-1:0] ca;
        bit            de;
        logic [AW-1:0] da;
        int            lat;
        bit            early;
        int            e_ci;
        logic [7:0]    e_cd;
        int            e_di;
        logic [7:0]    e_dd;
    } vec_t;

    vec_t          tbl[8];
    logic [AW-1:0] cpool[4];
    logic [AW-1:0] dpool[4];
    int            ci, di, seen;
    logic [7:0]    cd, dd;

    function automatic logic [7:0] mem(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[16], 7'd0} ^ 8'hA4;
    endfunction

    // Cycles from the request being sampled to the ok being visible.
    function automatic int dur(input bit h, input int lat);
        if (h) return 1;
        if (lat >= TO_LAT) return 256;
        return ((lat < 2) ? 2 : lat) + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_pair(input bit ce, input logic [AW-1:0] ca, input bit de,
                            input logic [AW-1:0] da, input int lat, input bit early,
                            output int oi_c, output int oi_d,
                            output logic [7:0] od_c, output logic [7:0] od_d);
        bit            en[2];
        logic [AW-1:0] ad[2];
        bit            hit[2];
        int            e_idx[2];
        logic [7:0]    e_dat[2];
        int            n_ok[2];
        int            g_idx[2];
        logic [7:0]    g_dat[2];
        bit            pend[2];
        int            order[$];
        logic [AW-1:0] e_gnt[$];
        logic [AW-1:0] o_gnt[$];
        int            off, s, e_tout, n_tout, idx, rcnt;
        bit            prev;
        en[0] = ce; en[1] = de; ad[0] = ca; ad[1] = da;
        for (int k = 0; k < 2; k++) begin
            hit[k]   = en[k] && m_vld[k] && (m_addr[k] == ad[k]);
            e_idx[k] = -1; e_dat[k] = 8'd0;
            n_ok[k]  = 0; g_idx[k] = -1; g_dat[k] = 8'd0; pend[k] = en[k];
        end
        if (ce && de) begin
            if (hit[1])      begin order.push_back(1); order.push_back(0); end
            else if (hit[0]) begin order.push_back(0); order.push_back(1); end
            else if (m_last) begin order.push_back(0); order.push_back(1); end
            else             begin order.push_back(1); order.push_back(0); end
        end else if (ce) order.push_back(0);
        else if (de)     order.push_back(1);
        off = 0; e_tout = 0;
        foreach (order[k]) begin
            s = order[k];
            e_idx[s] = off + dur(hit[s], lat);
            off = e_idx[s] + 1;
            if (hit[s]) e_dat[s] = m_dat[s];
            else begin
                e_gnt.push_back(ad[s]);
                m_last = (s == 1);
                if (lat >= TO_LAT) begin
                    e_dat[s] = 8'h00; e_tout++; m_vld[s] = 1'b0;
                end else begin
                    e_dat[s] = mem(ad[s]);
                    m_vld[s] = 1'b1; m_addr[s] = ad[s]; m_dat[s] = e_dat[s];
                end
            end
        end

        @(negedge clk);
        ctl_cs = ce; ctl_addr = ca; dec_cs = de; dec_addr = da; rom_ok = 1'b0;
        idx = 0; rcnt = 0; prev = 1'b0; n_tout = 0;
        while ((pend[0] || pend[1]) && idx < 400) begin
            @(negedge clk);
            idx++;
            if (rom_cs && !prev) o_gnt.push_back(rom_addr);
            prev = rom_cs;
            rcnt = rom_cs ? rcnt + 1 : 0;
            if (tout_err) n_tout++;
            if (ctl_ok) begin
                n_ok[0]++;
                if (pend[0]) begin
                    g_idx[0] = idx; g_dat[0] = ctl_data; pend[0] = 1'b0; ctl_cs = 1'b0;
                    chk("ctl_rom_cs_low_at_ok", rom_cs, 0);
                end
            end
            if (dec_ok) begin
                n_ok[1]++;
                if (pend[1]) begin
                    g_idx[1] = idx; g_dat[1] = dec_data; pend[1] = 1'b0; dec_cs = 1'b0;
                    chk("dec_rom_cs_low_at_ok", rom_cs, 0);
                end
            end
            rom_ok   = rom_cs && ((rcnt >= lat) || (early && rcnt == 1));
            rom_data = rom_ok ? mem(rom_addr) : 8'($urandom);
        end
        if (pend[0] || pend[1]) begin
            n_chk++; n_err++;
            $display("FAIL run_pair_budget: pending ctl=%0d dec=%0d after %0d cycles", pend[0], pend[1], idx);
        end
        rom_ok = 1'b0; ctl_cs = 1'b0; dec_cs = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ctl_ok) n_ok[0]++;
            if (dec_ok) n_ok[1]++;
            if (tout_err) n_tout++;
            if (rom_cs && !prev) o_gnt.push_back(rom_addr);
            prev = rom_cs;
        end
        chk("ctl_ok_count", n_ok[0], en[0]);
        chk("dec_ok_count", n_ok[1], en[1]);
        if (ce) begin
            chk("ctl_ok_cycle", g_idx[0], e_idx[0]);
            chk("ctl_data", g_dat[0], e_dat[0]);
        end
        if (de) begin
            chk("dec_ok_cycle", g_idx[1], e_idx[1]);
            chk("dec_data", g_dat[1], e_dat[1]);
        end
        chk("grant_count", o_gnt.size(), e_gnt.size());
        for (int k = 0; k < e_gnt.size() && k < o_gnt.size(); k++)
            chk("grant_addr", o_gnt[k], e_gnt[k]);
        chk("tout_count", n_tout, e_tout);
        oi_c = g_idx[0]; oi_d = g_idx[1]; od_c = g_dat[0]; od_d = g_dat[1];
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 1'b0; m_addr[k] = '0; m_dat[k] = 8'd0;
        end
        m_last = 1'b0;
        //          ce  ca           de  da           lat early ci  cd     di  dd
        tbl[0] = '{1'b0, 17'h00000, 1'b1, 17'h00100, 4, 1'b0, -1, 8'h00, 5, 8'hA5};
        tbl[1] = '{1'b0, 17'h00000, 1'b1, 17'h00100, 4, 1'b0, -1, 8'h00, 1, 8'hA5};
        tbl[2] = '{1'b1, 17'h00010, 1'b0, 17'h00000, 2, 1'b0,  3, 8'hB4, -1, 8'h00};
        tbl[3] = '{1'b1, 17'h00010, 1'b1, 17'h00100, 2, 1'b0,  3, 8'hB4, 1, 8'hA5};
        tbl[4] = '{1'b1, 17'h00010, 1'b1, 17'h00200, 2, 1'b0,  1, 8'hB4, 5, 8'hA6};
        tbl[5] = '{1'b1, 17'h1FF00, 1'b1, 17'h00300, 3, 1'b0,  4, 8'hDB, 9, 8'hA7};
        tbl[6] = '{1'b1, 17'h00020, 1'b0, 17'h00000, 1, 1'b0,  3, 8'h84, -1, 8'h00};
        tbl[7] = '{1'b0, 17'h00000, 1'b1, 17'h00400, 5, 1'b1, -1, 8'h00, 6, 8'hA0};
        cpool = '{17'h00010, 17'h1FF00, 17'h00020, 17'h0ABCD};
        dpool = '{17'h00100, 17'h00200, 17'h00300, 17'h10000};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_ctl_ok", ctl_ok, 0);
        chk("rst_dec_ok", dec_ok, 0);
        chk("rst_ctl_data", ctl_data, 0);
        chk("rst_dec_data", dec_data, 0);
        chk("rst_tout_err", tout_err, 0);
        rst_n = 1'b1;

        // Stray ok while idle must do nothing
        @(negedge clk);
        rom_ok = 1'b1; rom_data = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            chk("stray_ok_quiet", {ctl_ok, dec_ok, rom_cs, tout_err}, 0);
        end
        rom_ok = 1'b0;

        foreach (tbl[i]) begin
            run_pair(tbl[i].ce, tbl[i].ca, tbl[i].de, tbl[i].da, tbl[i].lat, tbl[i].early,
                     ci, di, cd, dd);
            if (tbl[i].ce) begin
                chk("tbl_ctl_cycle", ci, tbl[i].e_ci);
                chk("tbl_ctl_data", cd, tbl[i].e_cd);
            end
            if (tbl[i].de) begin
                chk("tbl_dec_cycle", di, tbl[i].e_di);
                chk("tbl_dec_data", dd, tbl[i].e_dd);
            end
        end

        // Timeout, then the same address must go to ROM again
        run_pair(1'b1, 17'h00030, 1'b0, '0, 9999, 1'b0, ci, di, cd, dd);
        chk("tout_ctl_cycle", ci, 256);
        chk("tout_ctl_data", cd, 8'h00);
        run_pair(1'b1, 17'h00030, 1'b0, '0, 2, 1'b0, ci, di, cd, dd);
        chk("after_tout_miss_cycle", ci, 3);
        chk("after_tout_data", cd, 8'h94);

        // Abort: dec drops cs while BUSY
        @(negedge clk);
        dec_cs = 1'b1; dec_addr = 17'h00600;
        @(negedge clk);
        chk("abort_rom_cs_up", rom_cs, 1);
        chk("abort_rom_addr", rom_addr, 17'h00600);
        dec_cs = 1'b0;
        @(negedge clk);
        chk("abort_rom_cs_drop", rom_cs, 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ctl_ok || dec_ok) seen++;
        end
        chk("abort_no_ok", seen, 0);
        m_last = 1'b1;
        run_pair(1'b0, '0, 1'b1, 17'h00400, 2, 1'b0, ci, di, cd, dd);
        chk("abort_cache_kept", di, 1);
        run_pair(1'b1, 17'h00010, 1'b1, 17'h00200, 2, 1'b0, ci, di, cd, dd);

        // Reset in BUSY, then a tie right after release
        @(negedge clk);
        dec_cs = 1'b1; dec_addr = 17'h00700;
        @(negedge clk);
        chk("rstbusy_rom_cs_up", rom_cs, 1);
        #2 rst_n = 1'b0;
        #1 chk("rstbusy_rom_cs_async", rom_cs, 0);
        dec_cs = 1'b0;
        for (int k = 0; k < 2; k++) m_vld[k] = 1'b0;
        m_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ctl_ok || dec_ok || rom_cs) seen++;
        end
        chk("rstbusy_quiet", seen, 0);
        run_pair(1'b1, 17'h00010, 1'b1, 17'h00200, 2, 1'b0, ci, di, cd, dd);
        chk("tie_dec_first", di, 3);
        chk("tie_ctl_second", ci, 7);

        // Randomized traffic against the model
        for (int r = 0; r < 40; r++) begin
            int msk;
            msk = $urandom_range(1, 3);
            run_pair(msk[0], cpool[$urandom_range(0, 3)], msk[1], dpool[$urandom_range(0, 3)],
                     $urandom_range(1, 6), 1'($urandom_range(0, 1)), ci, di, cd, dd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
